ahb_traffic_master: RTL and testbench
=====================================

# ahb_traffic_master

Self-checking AHB-Lite bus master that drives the system bus fabric: address decoder, slave-to-master response mux and the attached slaves. It runs a write pass followed by a read-back pass over a programmable word window. It compares read data against a regenerated LFSR pattern and reports mismatches and error responses. It replaces ad-hoc address stimulus in bus-level benches and serves as an on-chip memory self-test engine.

## Interface
- BASE_ADDR, 32'h2000_0000, byte address of the first word (word aligned)
- NUM_WORDS, 16, words per pass, 1..65535
- SEED, 32'h1, LFSR seed, must be nonzero

- HCLK  in  1  bus clock, all logic on rising edge
- SysRST  in  1  asynchronous, active-high reset
- start  in  1  one-cycle request; sampled only in IDLE
- HADDR  out  32  address phase address
- HTRANS  out  2  IDLE=2'b00, NONSEQ=2'b10 only
- HWRITE  out  1  1 in write pass
- HSIZE  out  3  constant 3'b010 (word)
- HBURST  out  3  constant 3'b000 (SINGLE)
- HPROT  out  4  constant 4'b0011
- HMASTLOCK  out  1  constant 0
- HWDATA  out  32  write data, valid in data phase
- HRDATA  in  32  muxed read data
- HREADY  in  1  muxed ready
- HRESP  in  1  muxed response, 1 = ERROR
- busy  out  1  high from cycle after accepted start until done
- done  out  1  one-cycle pulse at end of test
- mismatch_cnt  out  16  read compare failures, saturating at 16'hFFFF
- err_cnt  out  16  ERROR responses, saturating
- first_fail_addr  out  32  address of first mismatch or error; 0 if none

## Operation
- States: IDLE, WRITE, READ, DRAIN, ERRWAIT.
- IDLE, start=1: clear counters and first_fail_addr, load LFSR with SEED, index=0, go to WRITE.
- WRITE: issue NONSEQ write to BASE_ADDR+4*index. Data = current LFSR value. The LFSR steps and the index increments on each accepted address phase (HREADY=1).
- After NUM_WORDS writes are accepted: reload LFSR with SEED, index=0, go to READ with no idle cycle. The first read address phase overlaps the last write data phase.
- READ: issue NONSEQ reads the same way. The expected value is held in a data-phase register alongside the address.
- After the last read is accepted: go to DRAIN and drive HTRANS=IDLE.
- DRAIN: when the final data phase completes, pulse done and return to IDLE.
- LFSR: Galois, polynomial x^32+x^22+x^2+x+1, shift left, feedback mask 32'h0040_0007.
- Compare: at read data-phase completion (HREADY=1, HRESP=0), if HRDATA != expected, increment mismatch_cnt.
- first_fail_addr: latched only on the first failure (mismatch or error), using the data-phase address.

## Timing
- Reset values: HADDR=0, HTRANS=IDLE, HWRITE=0, HWDATA=0, busy=0, done=0, all counters 0, first_fail_addr=0.
- Constant outputs are held at their constants in reset too.
- Reset mid-operation: everything returns to reset values immediately. No transfer is completed.
- Address and control change only when HREADY=1. They are held stable through wait states.
- HWDATA is registered from the address-phase data when the address phase is accepted. It is held until its data phase completes.
- Zero-wait timing: start sampled at cycle 0; write i address at cycle 1+i; read i address at cycle 1+N+i; done and busy fall at cycle 2N+2.
- Error response, cycle 1 (HREADY=0, HRESP=1): increment err_cnt, enter ERRWAIT, drive HTRANS=IDLE in the next cycle (cancelling the pending address phase).
- Error response, cycle 2 (HREADY=1): re-issue the cancelled address phase on the following cycle, then resume WRITE, READ or DRAIN.
- The errored transfer is not retried and is not compared.
- start while busy: ignored. start coincident with done: ignored.
- NUM_WORDS=1: the single write and single read are back-to-back.

## Test plan
- Zero-wait RAM, BASE=32'h2000_0000, N=4: 8 NONSEQ transfers at cycles 1..8, done at cycle 10, mismatch_cnt=0, err_cnt=0.
- Slave adds 2 wait states on every transfer: address and control held stable during waits, HWDATA stable, done at cycle 26, mismatch_cnt=0.
- Slave corrupts read of word 2 (bit 0 flipped): mismatch_cnt=1, first_fail_addr=32'h2000_0008.
- Slave returns two-cycle ERROR on write 1: HTRANS=IDLE on the second error cycle, write 2 then re-issued; err_cnt=1, first_fail_addr=32'h2000_0004; read 1 then mismatches (mismatch_cnt=1).
- SysRST asserted during READ: all outputs return to reset values in the same cycle. A fresh start then runs to completion with clean counters.
- start pulsed at cycle 3 of a run: no restart and no counter clear; done still at cycle 10 (N=4, zero wait).

Source files
------------

// File: rtl/ahb_traffic_master.sv
// Self-checking AHB-Lite master: a write pass, then an LFSR-compared read-back pass over a word window.
// Latency: first address phase one cycle after start; with zero waits, done pulses 2*NUM_WORDS+2 cycles after start.
// Backpressure: address, control and HWDATA hold while HREADY=0; a two-cycle ERROR cancels the pending address phase and re-issues it.
module ahb_traffic_master #(
    parameter logic [31:0] BASE_ADDR = 32'h2000_0000,
    parameter int unsigned NUM_WORDS = 16,
    parameter logic [31:0] SEED      = 32'h1
) (
    input  logic        HCLK,
    input  logic        SysRST,
    input  logic        start,
    output logic [31:0] HADDR,
    output logic [1:0]  HTRANS,
    output logic        HWRITE,
    output logic [2:0]  HSIZE,
    output logic [2:0]  HBURST,
    output logic [3:0]  HPROT,
    output logic        HMASTLOCK,
    output logic [31:0] HWDATA,
    input  logic [31:0] HRDATA,
    input  logic        HREADY,
    input  logic        HRESP,
    output logic        busy,
    output logic        done,
    output logic [15:0] mismatch_cnt,
    output logic [15:0] err_cnt,
    output logic [31:0] first_fail_addr
);

    typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_ERRWAIT} state_t;

    localparam logic [1:0]  TR_IDLE   = 2'b00;
    localparam logic [1:0]  TR_NONSEQ = 2'b10;
    localparam logic [15:0] LAST_IDX  = 16'(NUM_WORDS - 1);
    localparam logic [31:0] LFSR_MASK = 32'h0040_0007;

    state_t      state_q, state_d, ret_q, ret_d;
    logic        pend_q, pend_d;
    logic [15:0] idx_q, idx_d;
    logic [31:0] lfsr_q, lfsr_d;
    logic [1:0]  htrans_q, htrans_d;
    logic [31:0] haddr_q, haddr_d;
    logic        hwrite_q, hwrite_d;
    logic [31:0] hwdata_q, hwdata_d;
    logic        dp_vld_q, dp_vld_d;
    logic        dp_write_q, dp_write_d;
    logic [31:0] dp_addr_q, dp_addr_d;
    logic [31:0] dp_exp_q, dp_exp_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic [15:0] mis_q, mis_d;
    logic [15:0] err_q, err_d;
    logic [31:0] ffa_q, ffa_d;
    logic        seen_q, seen_d;

    logic ap_vld, ap_acc, mis_hit, err_first;

    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {v[30:0], 1'b0} ^ (v[31] ? LFSR_MASK : 32'h0);
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign ap_vld    = (htrans_q == TR_NONSEQ);
    assign ap_acc    = HREADY && ap_vld;
    // Read data phase completing OK with data different from the regenerated pattern.
    assign mis_hit   = HREADY && !HRESP && dp_vld_q && !dp_write_q && (HRDATA != dp_exp_q);
    // First cycle of a two-cycle ERROR response; ERRWAIT already owns the second cycle.
    assign err_first = dp_vld_q && !HREADY && HRESP && (state_q != S_ERRWAIT) && (state_q != S_IDLE);

    // Next-state, address-phase generation, data-phase tracking and result counters.
    always_comb begin
        state_d    = state_q;
        ret_d      = ret_q;
        pend_d     = pend_q;
        idx_d      = idx_q;
        lfsr_d     = lfsr_q;
        htrans_d   = htrans_q;
        haddr_d    = haddr_q;
        hwrite_d   = hwrite_q;
        hwdata_d   = hwdata_q;
        dp_vld_d   = dp_vld_q;
        dp_write_d = dp_write_q;
        dp_addr_d  = dp_addr_q;
        dp_exp_d   = dp_exp_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        mis_d      = mis_q;
        err_d      = err_q;
        ffa_d      = ffa_q;
        seen_d     = seen_q;

        // The address phase on the bus becomes the data phase whenever HREADY completes a cycle.
        if (HREADY) begin
            dp_vld_d   = ap_vld;
            dp_write_d = hwrite_q;
            dp_addr_d  = haddr_q;
            dp_exp_d   = lfsr_q;
            if (ap_vld && hwrite_q) begin
                hwdata_d = lfsr_q;
            end
        end

        if (mis_hit) begin
            mis_d = sat_inc(mis_q);
        end
        if (err_first) begin
            err_d = sat_inc(err_q);
        end
        if ((mis_hit || err_first) && !seen_q) begin
            ffa_d  = dp_addr_q;
            seen_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                // A start landing on the done cycle belongs to the run that just ended.
                if (start && !done_q) begin
                    mis_d    = 16'd0;
                    err_d    = 16'd0;
                    ffa_d    = 32'd0;
                    seen_d   = 1'b0;
                    lfsr_d   = SEED;
                    idx_d    = 16'd0;
                    haddr_d  = BASE_ADDR;
                    hwrite_d = 1'b1;
                    htrans_d = TR_NONSEQ;
                    busy_d   = 1'b1;
                    state_d  = S_WRITE;
                end
            end
            S_WRITE, S_READ, S_DRAIN: begin
                if (err_first) begin
                    ret_d    = state_q;
                    pend_d   = ap_vld;
                    htrans_d = TR_IDLE;
                    state_d  = S_ERRWAIT;
                end else if (state_q == S_DRAIN) begin
                    if (HREADY && dp_vld_q) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end else if (ap_acc) begin
                    if (idx_q != LAST_IDX) begin
                        idx_d   = idx_q + 16'd1;
                        lfsr_d  = lfsr_step(lfsr_q);
                        haddr_d = haddr_q + 32'd4;
                    end else if (state_q == S_WRITE) begin
                        // Read pass starts without an idle cycle, regenerating the same pattern.
                        idx_d    = 16'd0;
                        lfsr_d   = SEED;
                        haddr_d  = BASE_ADDR;
                        hwrite_d = 1'b0;
                        state_d  = S_READ;
                    end else begin
                        htrans_d = TR_IDLE;
                        state_d  = S_DRAIN;
                    end
                end
            end
            S_ERRWAIT: begin
                // Errored transfer completes here; it is neither retried nor compared.
                if (HREADY) begin
                    if (pend_q) begin
                        htrans_d = TR_NONSEQ;
                        state_d  = ret_q;
                    end else begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State and output registers; reset returns the bus to IDLE at once.
    always_ff @(posedge HCLK or posedge SysRST) begin
        if (SysRST) begin
            state_q    <= S_IDLE;
            ret_q      <= S_IDLE;
            pend_q     <= 1'b0;
            idx_q      <= 16'd0;
            lfsr_q     <= 32'd0;
            htrans_q   <= TR_IDLE;
            haddr_q    <= 32'd0;
            hwrite_q   <= 1'b0;
            hwdata_q   <= 32'd0;
            dp_vld_q   <= 1'b0;
            dp_write_q <= 1'b0;
            dp_addr_q  <= 32'd0;
            dp_exp_q   <= 32'd0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            mis_q      <= 16'd0;
            err_q      <= 16'd0;
            ffa_q      <= 32'd0;
            seen_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            ret_q      <= ret_d;
            pend_q     <= pend_d;
            idx_q      <= idx_d;
            lfsr_q     <= lfsr_d;
            htrans_q   <= htrans_d;
            haddr_q    <= haddr_d;
            hwrite_q   <= hwrite_d;
            hwdata_q   <= hwdata_d;
            dp_vld_q   <= dp_vld_d;
            dp_write_q <= dp_write_d;
            dp_addr_q  <= dp_addr_d;
            dp_exp_q   <= dp_exp_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            mis_q      <= mis_d;
            err_q      <= err_d;
            ffa_q      <= ffa_d;
            seen_q     <= seen_d;
        end
    end

    assign HADDR           = haddr_q;
    assign HTRANS          = htrans_q;
    assign HWRITE          = hwrite_q;
    assign HWDATA          = hwdata_q;
    assign HSIZE           = 3'b010;
    assign HBURST          = 3'b000;
    assign HPROT           = 4'b0011;
    assign HMASTLOCK       = 1'b0;
    assign busy            = busy_q;
    assign done            = done_q;
    assign mismatch_cnt    = mis_q;
    assign err_cnt         = err_q;
    assign first_fail_addr = ffa_q;

endmodule

// File: tb/tb_ahb_traffic_master.sv
`timescale 1ns/1ps
module tb_ahb_traffic_master;

    localparam logic [31:0] BASE = 32'h2000_0000;
    localparam int          N    = 4;
    localparam logic [31:0] SEED = 32'h1;

    logic        HCLK = 1'b0;
    logic        SysRST, start;
    logic [31:0] HADDR, HWDATA, HRDATA, first_fail_addr;
    logic [1:0]  HTRANS;
    logic        HWRITE, HMASTLOCK, HREADY, HRESP, busy, done;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [15:0] mismatch_cnt, err_cnt;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 HCLK = ~HCLK;
    always @(posedge HCLK) cyc <= cyc + 1;

    ahb_traffic_master #(.BASE_ADDR(BASE), .NUM_WORDS(N), .SEED(SEED)) dut (
        .HCLK(HCLK), .SysRST(SysRST), .start(start),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE),
        .HBURST(HBURST), .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HRDATA(HRDATA), .HREADY(HREADY), .HRESP(HRESP),
        .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt), .err_cnt(err_cnt),
        .first_fail_addr(first_fail_addr)
    );

    typedef struct {
        logic [31:0] addr;
        logic        wr;
        logic [31:0] dat;
    } xfer_t;

    xfer_t sb_q[$];

    // Slave model state and knobs
    logic [31:0] mem [0:3];
    int          ws = 0;
    int          corrupt_idx = -1;
    int          err_idx = -1;
    logic        s_dvld = 1'b0, s_dwrite = 1'b0;
    logic [31:0] s_daddr = 32'd0, s_dexp = 32'd0;
    int          s_wcnt = 0, s_err = 0;
    logic        prev_rdy = 1'b1, prev_resp = 1'b0, a_write = 1'b0;
    logic [1:0]  a_trans = 2'b00;
    logic [31:0] a_addr = 32'd0, prev_hwdata = 32'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        return {v[30:0], 1'b0} ^ (v[31] ? 32'h0040_0007 : 32'h0);
    endfunction

    // Expected accepted address phases of one full run, in bus order.
    task automatic push_run();
        logic [31:0] v;
        xfer_t x;
        v = SEED;
        for (int i = 0; i < N; i++) begin
            x.addr = BASE + 32'(4 * i); x.wr = 1'b1; x.dat = v;
            sb_q.push_back(x);
            v = lfsr_next(v);
        end
        v = SEED;
        for (int i = 0; i < N; i++) begin
            x.addr = BASE + 32'(4 * i); x.wr = 1'b0; x.dat = v;
            sb_q.push_back(x);
            v = lfsr_next(v);
        end
    endtask

    // One slave cycle, evaluated just after the rising edge.
    task automatic slave_step();
        xfer_t x;
        int    idx;
        if (SysRST) begin
            s_dvld = 1'b0; s_err = 0; s_wcnt = 0;
            HREADY = 1'b1; HRESP = 1'b0;
            prev_rdy = 1'b1; prev_resp = 1'b0; a_trans = 2'b00;
            return;
        end
        if (!prev_rdy && !prev_resp && a_trans == 2'b10) begin
            chk("addr_hold", HADDR, a_addr);
            chk("ctrl_hold", 32'({HTRANS, HWRITE}), 32'({a_trans, a_write}));
        end
        if (!prev_rdy && !prev_resp && s_dvld && s_dwrite)
            chk("wdata_hold", HWDATA, prev_hwdata);
        if (prev_rdy) begin
            s_dvld = (a_trans == 2'b10); s_dwrite = a_write; s_daddr = a_addr;
            s_wcnt = ws; s_err = 0;
            if (s_dvld) begin
                chk("sb_nonempty", 32'(sb_q.size() > 0), 32'd1);
                if (sb_q.size() > 0) begin
                    x = sb_q.pop_front();
                    chk("sb_addr", a_addr, x.addr);
                    chk("sb_write", 32'(a_write), 32'(x.wr));
                    s_dexp = x.dat;
                end
                if (a_write && err_idx >= 0 && a_addr == BASE + 32'(4 * err_idx)) begin
                    s_err = 1; err_idx = -1;
                end
            end
        end
        idx = int'(s_daddr[3:2]);
        if (!s_dvld) begin
            HREADY = 1'b1; HRESP = 1'b0;
        end else if (s_err == 1) begin
            HREADY = 1'b0; HRESP = 1'b1; s_err = 2;
        end else if (s_err == 2) begin
            HREADY = 1'b1; HRESP = 1'b1; s_err = 0;
            chk("err_cancel_idle", 32'(HTRANS), 32'd0);
        end else if (s_wcnt > 0) begin
            HREADY = 1'b0; HRESP = 1'b0; s_wcnt--;
        end else begin
            HREADY = 1'b1; HRESP = 1'b0;
            if (s_dwrite) begin
                chk("wdata", HWDATA, s_dexp);
                mem[idx] = HWDATA;
            end else begin
                HRDATA = mem[idx] ^ ((idx == corrupt_idx) ? 32'h1 : 32'h0);
            end
        end
        prev_rdy = HREADY; prev_resp = HRESP;
        a_trans = HTRANS; a_addr = HADDR; a_write = HWRITE; prev_hwdata = HWDATA;
    endtask

    initial begin
        forever begin
            @(posedge HCLK);
            #1;
            slave_step();
        end
    end

    task automatic run_test(input string tag, input int extra_at, input int exp_done,
                            input int exp_mis, input int exp_err, input logic [31:0] exp_ffa);
        int t0;
        int dcyc;
        bit got;
        for (int i = 0; i < 4; i++) mem[i] = 32'd0;
        push_run();
        start = 1'b1;
        t0 = cyc;
        got = 1'b0;
        dcyc = -1;
        for (int k = 0; k < 200 && !got; k++) begin
            @(posedge HCLK); #2;
            start = ((cyc - t0) == extra_at);
            if ((cyc - t0) == 1) chk({tag, "_busy_c1"}, 32'(busy), 32'd1);
            if (done) begin
                got = 1'b1;
                dcyc = cyc - t0;
            end
        end
        chk({tag, "_done_seen"}, 32'(got), 32'd1);
        chk({tag, "_done_cycle"}, 32'(dcyc), 32'(exp_done));
        chk({tag, "_busy_at_done"}, 32'(busy), 32'd0);
        chk({tag, "_mismatch"}, 32'(mismatch_cnt), 32'(exp_mis));
        chk({tag, "_errs"}, 32'(err_cnt), 32'(exp_err));
        chk({tag, "_ffa"}, first_fail_addr, exp_ffa);
        @(posedge HCLK); #2;
        start = 1'b0;
        chk({tag, "_idle_after"}, 32'({busy, done, HTRANS}), 32'd0);
        chk({tag, "_sb_drained"}, 32'(sb_q.size()), 32'd0);
        sb_q.delete();
    endtask

    initial begin
        SysRST = 1'b1; start = 1'b0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'd0;
        for (int i = 0; i < 4; i++) mem[i] = 32'd0;
        repeat (2) @(posedge HCLK);
        #2;
        chk("rst_haddr", HADDR, 32'd0);
        chk("rst_ctrl", 32'({HTRANS, HWRITE}), 32'd0);
        chk("rst_hwdata", HWDATA, 32'd0);
        chk("rst_status", 32'({busy, done}), 32'd0);
        chk("rst_cnts", {mismatch_cnt, err_cnt}, 32'd0);
        chk("rst_ffa", first_fail_addr, 32'd0);
        chk("rst_consts", 32'({HSIZE, HBURST, HPROT, HMASTLOCK}), 32'({3'b010, 3'b000, 4'b0011, 1'b0}));
        SysRST = 1'b0;
        @(posedge HCLK); #2;

        // Zero-wait RAM
        run_test("zw", -1, 10, 0, 0, 32'd0);

        // Two wait states on every transfer
        ws = 2;
        run_test("ws2", -1, 26, 0, 0, 32'd0);
        ws = 0;

        // Corrupted read of word 2
        corrupt_idx = 2;
        run_test("corrupt", -1, 10, 1, 0, 32'h2000_0008);
        corrupt_idx = -1;

        // Two-cycle ERROR on write 1; read 1 then finds stale memory
        err_idx = 1;
        run_test("errw1", -1, 12, 1, 1, 32'h2000_0004);
        err_idx = -1;

        // Reset in the middle of the read pass
        for (int i = 0; i < 4; i++) mem[i] = 32'd0;
        push_run();
        start = 1'b1;
        @(posedge HCLK); #2;
        start = 1'b0;
        repeat (5) @(posedge HCLK);
        #2;
        chk("midrst_in_read", 32'({HTRANS, HWRITE}), 32'({2'b10, 1'b0}));
        SysRST = 1'b1;
        #1;
        chk("midrst_haddr", HADDR, 32'd0);
        chk("midrst_ctrl", 32'({HTRANS, HWRITE}), 32'd0);
        chk("midrst_hwdata", HWDATA, 32'd0);
        chk("midrst_status", 32'({busy, done}), 32'd0);
        chk("midrst_cnts", {mismatch_cnt, err_cnt}, 32'd0);
        chk("midrst_consts", 32'({HSIZE, HBURST, HPROT, HMASTLOCK}), 32'({3'b010, 3'b000, 4'b0011, 1'b0}));
        sb_q.delete();
        repeat (2) @(posedge HCLK);
        #2;
        SysRST = 1'b0;
        @(posedge HCLK); #2;
        run_test("rerun", -1, 10, 0, 0, 32'd0);

        // start while busy, then start coincident with done
        run_test("start_c3", 3, 10, 0, 0, 32'd0);
        run_test("start_at_done", 10, 10, 0, 0, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
